// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus DMA arbiter: arbiter state encoding,
// bus widths and a pointer-width helper.
package qbus_pkg;

    localparam int ADR_W = 16;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_CPU = 2'd0,
        ST_GAP = 2'd1,
        ST_DMA = 2'd2
    } arb_state_t;

    // An index into an n-entry vector needs at least one bit, even for n == 1.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qbus_dma_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the
// pointer, wrapping modulo N. Also reused by the interrupt controller.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = PW'((int'(i_ptr) + i) % N);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule

// File: rtl/qbus_dma_arbiter.sv
// Q-bus style arbiter sharing the Wishbone bus between the CPU and NDMA DMA
// masters. Optional bus-timeout watchdog enabled by QBUS_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_CPU  | CPU owns the bus; slot counter runs until DMA may take over
// ST_GAP  | one dead clock, no grant; round-robin winner is picked here
// ST_DMA  | DMA master r_idx owns the bus; hold counter bounds the tenure
module qbus_dma_arbiter
    import qbus_pkg::*;
#(
    parameter int NDMA     = 2,
    parameter int MAX_HOLD = 64,
    parameter int CPU_SLOT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk_p,
    input  logic                  rst_n,
    input  logic                  cpu_stb_i,
    input  logic [ADR_W-1:0]      cpu_adr_i,
    input  logic [DAT_W-1:0]      cpu_dat_i,
    input  logic                  cpu_we_i,
    input  logic [SEL_W-1:0]      cpu_sel_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_ack_o,
    input  logic [NDMA-1:0]       dma_req_i,
    input  logic [NDMA-1:0]       dma_stb_i,
    input  logic [ADR_W*NDMA-1:0] dma_adr_i,
    input  logic [DAT_W*NDMA-1:0] dma_dat_i,
    input  logic [NDMA-1:0]       dma_we_i,
    input  logic [SEL_W*NDMA-1:0] dma_sel_i,
    output logic [NDMA-1:0]       dma_gnt_o,
    output logic [NDMA-1:0]       dma_ack_o,
    output logic [ADR_W-1:0]      bus_adr_o,
    output logic [DAT_W-1:0]      bus_dat_o,
    output logic                  bus_we_o,
    output logic [SEL_W-1:0]      bus_sel_o,
    output logic                  bus_stb_o,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o
);

    localparam int PW     = ptr_w(NDMA);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int SLOT_W = $clog2(CPU_SLOT + 1);

    arb_state_t        r_state;
    logic              r_cpu_gnt;
    logic [NDMA-1:0]   r_dma_gnt;
    logic [PW-1:0]     r_idx;
    logic [PW-1:0]     r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic [SLOT_W-1:0] r_slot;
    logic              r_first;

    logic [NDMA-1:0]   w_pick_gnt;
    logic [PW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_tmo_ack;
    logic              w_ack;
    logic              w_cpu_go;
    logic              w_release;
    logic [PW-1:0]     w_ptr_nxt;

    rr_pick #(
        .N  (NDMA),
        .PW (PW)
    ) u_rr_pick (
        .i_req (dma_req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // The CPU slot is waived until the first DMA tenure after reset.
    assign w_cpu_go  = (|dma_req_i) && !cpu_stb_i &&
                       (r_first || (r_slot >= SLOT_W'(CPU_SLOT)));
    assign w_release = (((!dma_req_i[r_idx]) || (r_hold >= HOLD_W'(MAX_HOLD))) &&
                        !dma_stb_i[r_idx]) || w_tmo_ack;
    assign w_ptr_nxt = (r_idx == PW'(NDMA - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CPU;
            r_cpu_gnt <= 1'b1;
            r_dma_gnt <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_slot    <= '0;
            r_first   <= 1'b1;
        end else begin
            case (r_state)
                ST_CPU: begin
                    if (r_slot != SLOT_W'(CPU_SLOT))
                        r_slot <= r_slot + 1'b1;
                    if (w_cpu_go) begin
                        r_state   <= ST_GAP;
                        r_cpu_gnt <= 1'b0;
                        r_first   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (w_pick_any) begin
                        r_state   <= ST_DMA;
                        r_dma_gnt <= w_pick_gnt;
                        r_idx     <= w_pick_idx;
                        // The grant clock itself is the first clock of the tenure.
                        r_hold    <= HOLD_W'(1);
                    end else begin
                        r_state   <= ST_CPU;
                        r_cpu_gnt <= 1'b1;
                    end
                end
                ST_DMA: begin
                    if (r_hold != HOLD_W'(MAX_HOLD))
                        r_hold <= r_hold + 1'b1;
                    if (w_release) begin
                        r_state   <= ST_CPU;
                        r_cpu_gnt <= 1'b1;
                        r_dma_gnt <= '0;
                        r_ptr     <= w_ptr_nxt;
                        r_slot    <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_CPU;
                    r_cpu_gnt <= 1'b1;
                    r_dma_gnt <= '0;
                end
            endcase
        end
    end

    assign cpu_gnt_o = r_cpu_gnt;
    assign dma_gnt_o = r_dma_gnt;

    always_comb begin
        bus_adr_o = '0;
        bus_dat_o = '0;
        bus_we_o  = 1'b0;
        bus_sel_o = '0;
        bus_stb_o = 1'b0;
        if (r_cpu_gnt) begin
            bus_adr_o = cpu_adr_i;
            bus_dat_o = cpu_dat_i;
            bus_we_o  = cpu_we_i;
            bus_sel_o = cpu_sel_i;
            bus_stb_o = cpu_stb_i;
        end
        for (int k = 0; k < NDMA; k++) begin
            if (r_dma_gnt[k]) begin
                bus_adr_o = dma_adr_i[ADR_W*k +: ADR_W];
                bus_dat_o = dma_dat_i[DAT_W*k +: DAT_W];
                bus_we_o  = dma_we_i[k];
                bus_sel_o = dma_sel_i[SEL_W*k +: SEL_W];
                bus_stb_o = dma_stb_i[k];
            end
        end
    end

    assign w_ack     = bus_ack_i | w_tmo_ack;
    assign cpu_ack_o = r_cpu_gnt & w_ack;
    assign dma_ack_o = r_dma_gnt & {NDMA{w_ack}};

`ifdef QBUS_ARB_TIMEOUT_EN
    logic [7:0] r_tmo;
    logic       r_err;

    // r_err doubles as the synthetic ack; clearing the count with it keeps
    // the still-high strobe from re-arming the watchdog in the same cycle.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (!bus_stb_o || bus_ack_i || r_err)
                r_tmo <= '0;
            else if (r_tmo != 8'hFF)
                r_tmo <= r_tmo + 1'b1;
            r_err <= bus_stb_o && !bus_ack_i && !r_err && (r_tmo == 8'(TIMEOUT - 1));
        end
    end

    assign bus_err_o = r_err;
    assign w_tmo_ack = r_err;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT;
    assign bus_err_o    = 1'b0;
    assign w_tmo_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Self-checking bench for qbus_dma_arbiter: CPU pass-through vector table,
// grant-sequence scoreboard and hand sequences for the multi-cycle cases.
module tb_qbus_dma_arbiter;

    localparam int NDMA     = 2;
    localparam int MAX_HOLD = 64;
    localparam int CPU_SLOT = 4;
    localparam int TIMEOUT  = 255;

    logic        clk_p = 1'b0;
    logic        rst_n;
    logic        cpu_stb_i;
    logic [15:0] cpu_adr_i;
    logic [15:0] cpu_dat_i;
    logic        cpu_we_i;
    logic [1:0]  cpu_sel_i;
    logic        cpu_gnt_o;
    logic        cpu_ack_o;
    logic [1:0]  dma_req_i;
    logic [1:0]  dma_stb_i;
    logic [31:0] dma_adr_i;
    logic [31:0] dma_dat_i;
    logic [1:0]  dma_we_i;
    logic [3:0]  dma_sel_i;
    logic [1:0]  dma_gnt_o;
    logic [1:0]  dma_ack_o;
    logic [15:0] bus_adr_o;
    logic [15:0] bus_dat_o;
    logic        bus_we_o;
    logic [1:0]  bus_sel_o;
    logic        bus_stb_o;
    logic        bus_ack_i;
    logic        bus_err_o;

    qbus_dma_arbiter #(
        .NDMA(NDMA), .MAX_HOLD(MAX_HOLD), .CPU_SLOT(CPU_SLOT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_p(clk_p), .rst_n(rst_n),
        .cpu_stb_i(cpu_stb_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_gnt_o(cpu_gnt_o), .cpu_ack_o(cpu_ack_o),
        .dma_req_i(dma_req_i), .dma_stb_i(dma_stb_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
        .dma_we_i(dma_we_i), .dma_sel_i(dma_sel_i), .dma_gnt_o(dma_gnt_o), .dma_ack_o(dma_ack_o),
        .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_stb_o(bus_stb_o), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk_p = ~clk_p;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk_p);
        #1;
    endtask

    // Grant scoreboard: expected {cpu_gnt, dma_gnt} values in order of change.
    logic [2:0] exp_q[$];
    logic       mon_en      = 1'b0;
    logic       mon_was     = 1'b0;
    logic       dma_ten_chk = 1'b0;
    logic       cpu_after_dma;
    logic [2:0] prev;
    logic [2:0] cur;
    int         ten;
    int         overlap = 0;

    always @(negedge clk_p) begin
        cur = {cpu_gnt_o, dma_gnt_o};
        if (cpu_gnt_o && (dma_gnt_o != 2'b00)) overlap++;
        if (mon_en && !mon_was) begin
            prev          = cur;
            ten           = 1;
            cpu_after_dma = 1'b0;
        end else if (mon_en) begin
            if (cur != prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL grant_seq: unexpected grant %b after %b", cur, prev);
                end else begin
                    chk("grant_seq", 64'(cur), 64'(exp_q.pop_front()));
                end
                if ((prev[1:0] != 2'b00) && dma_ten_chk)
                    chk($sformatf("dma_tenure_%0d", ten),
                        64'((ten <= MAX_HOLD) && (ten >= MAX_HOLD - 1)), 64'd1);
                if ((prev == 3'b100) && cpu_after_dma)
                    chk($sformatf("cpu_slot_%0d", ten), 64'(ten >= CPU_SLOT), 64'd1);
                cpu_after_dma = (cur == 3'b100) && (prev[1:0] != 2'b00);
                prev = cur;
                ten  = 1;
            end else begin
                ten++;
            end
        end
        mon_was = mon_en;
    end

    task automatic wait_q(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_dma(input logic [1:0] g, input int budget, input string name,
                            output int cycles);
        cycles = 0;
        while (dma_gnt_o !== g && cycles < budget) begin
            step;
            cycles++;
        end
        chk(name, 64'(dma_gnt_o), 64'(g));
    endtask

    typedef struct {
        logic        stb;
        logic [15:0] adr;
        logic [15:0] dat;
        logic        we;
        logic [1:0]  sel;
        logic        ack;
        logic [35:0] e_bus;   // {adr, dat, we, sel, stb}
        logic        e_cack;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int bad;
        int cnt;

        tbl[0] = '{1'b1, 16'o001000, 16'o000000, 1'b0, 2'b11, 1'b0,
                   {16'o001000, 16'o000000, 1'b0, 2'b11, 1'b1}, 1'b0};
        tbl[1] = '{1'b1, 16'o001000, 16'o000000, 1'b0, 2'b11, 1'b1,
                   {16'o001000, 16'o000000, 1'b0, 2'b11, 1'b1}, 1'b1};
        tbl[2] = '{1'b1, 16'o160000, 16'o052525, 1'b1, 2'b01, 1'b1,
                   {16'o160000, 16'o052525, 1'b1, 2'b01, 1'b1}, 1'b1};
        tbl[3] = '{1'b1, 16'o177566, 16'o000101, 1'b1, 2'b10, 1'b0,
                   {16'o177566, 16'o000101, 1'b1, 2'b10, 1'b1}, 1'b0};
        tbl[4] = '{1'b0, 16'o012345, 16'o000000, 1'b0, 2'b00, 1'b1,
                   {16'o012345, 16'o000000, 1'b0, 2'b00, 1'b0}, 1'b1};
        tbl[5] = '{1'b0, 16'o004000, 16'o000000, 1'b0, 2'b00, 1'b0,
                   {16'o004000, 16'o000000, 1'b0, 2'b00, 1'b0}, 1'b0};

        rst_n = 1'b0;
        cpu_stb_i = 1'b0; cpu_adr_i = '0; cpu_dat_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0;
        dma_req_i = '0; dma_stb_i = '0; dma_adr_i = '0; dma_dat_i = '0; dma_we_i = '0;
        dma_sel_i = '0; bus_ack_i = 1'b0;
        repeat (3) step;
        chk("reset_grants", 64'({cpu_gnt_o, dma_gnt_o, bus_err_o}), 64'b1_00_0);
        rst_n = 1'b1;
        step;

        // 1: CPU pass-through; DMA side strobes without request must not leak.
        dma_stb_i = 2'b11;
        dma_adr_i = {16'hBEEF, 16'hDEAD};
        dma_dat_i = {16'h5A5A, 16'hA5A5};
        for (int i = 0; i < 6; i++) begin
            step;
            cpu_stb_i = tbl[i].stb; cpu_adr_i = tbl[i].adr; cpu_dat_i = tbl[i].dat;
            cpu_we_i  = tbl[i].we;  cpu_sel_i = tbl[i].sel; bus_ack_i = tbl[i].ack;
            #2;
            chk($sformatf("tbl%0d_bus", i),
                64'({bus_adr_o, bus_dat_o, bus_we_o, bus_sel_o, bus_stb_o}), 64'(tbl[i].e_bus));
            chk($sformatf("tbl%0d_ack", i), 64'({cpu_ack_o, dma_ack_o}), 64'({tbl[i].e_cack, 2'b00}));
        end
        dma_stb_i = 2'b00;
        bus_ack_i = 1'b0;
        mon_en = 1'b1;
        step;

        // 2: single request, 2-clock grant latency, 1-clock release latency.
        dma_adr_i[15:0] = 16'o157000;
        dma_req_i = 2'b01;
        exp_q.push_back(3'b000); exp_q.push_back(3'b001);
        step;
        chk("t2_gap", 64'({cpu_gnt_o, dma_gnt_o, bus_stb_o, bus_adr_o}), 64'd0);
        step;
        chk("t2_grant", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_01);
        dma_stb_i = 2'b01; dma_we_i = 2'b01; dma_sel_i = 4'b0011;
        #2;
        chk("t2_bus", 64'({bus_adr_o, bus_dat_o, bus_we_o, bus_sel_o, bus_stb_o}),
            64'({16'o157000, 16'hA5A5, 1'b1, 2'b11, 1'b1}));
        bus_ack_i = 1'b1;
        #1;
        chk("t2_ack_route", 64'({cpu_ack_o, dma_ack_o}), 64'b0_01);
        step;
        bus_ack_i = 1'b0; dma_stb_i = 2'b00; dma_we_i = 2'b00; dma_req_i = 2'b00;
        exp_q.push_back(3'b100);
        step;
        chk("t2_release", 64'({cpu_gnt_o, dma_gnt_o}), 64'b1_00);
        wait_q(5, "t2_seq_done");

        // 3: both requesting; pointer is now 1, forced releases alternate masters.
        dma_ten_chk = 1'b1;
        dma_req_i = 2'b11;
        exp_q.push_back(3'b000); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        exp_q.push_back(3'b000); exp_q.push_back(3'b001); exp_q.push_back(3'b100);
        exp_q.push_back(3'b000); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        wait_q(600, "t3_seq_done");
        dma_req_i = 2'b00;
        dma_ten_chk = 1'b0;
        step;

        // 3b: forced release waits for the strobe tail, then master re-competes.
        dma_req_i = 2'b01;
        exp_q.push_back(3'b000); exp_q.push_back(3'b001);
        wait_dma(2'b01, 20, "t3b_grant", cyc);
        dma_stb_i = 2'b01;
        repeat (MAX_HOLD + 6) step;
        chk("t3b_hold_for_strobe", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_01);
        exp_q.push_back(3'b100); exp_q.push_back(3'b000); exp_q.push_back(3'b001);
        dma_stb_i = 2'b00;
        step;
        chk("t3b_release", 64'({cpu_gnt_o, dma_gnt_o}), 64'b1_00);
        wait_dma(2'b01, 30, "t3b_regrant", cyc);
        chk("t3b_regrant_after_slot", 64'(cyc >= CPU_SLOT + 1), 64'd1);
        dma_req_i = 2'b00;
        exp_q.push_back(3'b100);
        wait_q(10, "t3b_seq_done");

        // 4: CPU cycle in progress with slow ack is never cut.
        cpu_stb_i = 1'b1; cpu_adr_i = 16'o001000; cpu_we_i = 1'b0;
        dma_req_i = 2'b01;
        exp_q.push_back(3'b000); exp_q.push_back(3'b001);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step;
            if (!cpu_gnt_o || (dma_gnt_o != 2'b00)) bad++;
        end
        chk("t4_cpu_not_cut", 64'(bad), 64'd0);
        bus_ack_i = 1'b1;
        #1;
        chk("t4_cpu_ack", 64'({cpu_ack_o, dma_ack_o}), 64'b1_00);
        step;
        cpu_stb_i = 1'b0; bus_ack_i = 1'b0;
        step;
        chk("t4_gap", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_00);
        step;
        chk("t4_grant", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_01);
        dma_req_i = 2'b00;
        exp_q.push_back(3'b100);
        wait_q(10, "t4_seq_done");
        mon_en = 1'b0;

        // 5: stuck DMA cycle to a nonexistent address.
        dma_req_i = 2'b01;
        wait_dma(2'b01, 30, "t5_grant", cyc);
        dma_adr_i[15:0] = 16'o177700;
        dma_stb_i = 2'b01;
`ifdef QBUS_ARB_TIMEOUT_EN
        cnt = 0;
        while (!bus_err_o && cnt < 400) begin
            step;
            cnt++;
        end
        chk("t5_err_clock", 64'(cnt), 64'(TIMEOUT));
        chk("t5_synth_ack", 64'({cpu_ack_o, dma_ack_o}), 64'b0_01);
        step;
        chk("t5_revoked", 64'({cpu_gnt_o, dma_gnt_o, bus_err_o}), 64'b1_00_0);
`else
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step;
            if (bus_err_o !== 1'b0) cnt++;
        end
        chk("t5_no_err", 64'(cnt), 64'd0);
        chk("t5_bus_hangs", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_01);
`endif
        dma_stb_i = 2'b00; dma_req_i = 2'b00;
        repeat (3) step;

        // 6: reset during a DMA write; pointer (left at 1) must return to 0.
        dma_req_i = 2'b01;
        wait_dma(2'b01, 30, "t6_grant", cyc);
        dma_stb_i = 2'b01; dma_we_i = 2'b01;
        step;
        @(negedge clk_p);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 64'({cpu_gnt_o, dma_gnt_o, bus_stb_o}), 64'b1_00_0);
        dma_stb_i = 2'b00; dma_we_i = 2'b00; dma_req_i = 2'b11;
        @(posedge clk_p);
        #3;
        rst_n = 1'b1;
        step;
        chk("t6_gap_first_entry", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_00);
        step;
        chk("t6_ptr_zero", 64'({cpu_gnt_o, dma_gnt_o}), 64'b0_01);
        dma_req_i = 2'b00;
        repeat (3) step;

        chk("no_grant_overlap", 64'(overlap), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
